clk_en_gen: RTL and testbench
=============================

Name: clk_en_gen

Overview:
- Parametrised successor to the team's single free-running clock divider.
- Keeps the free-running `clkdiv` bus.
- Adds N_CH independently programmable divide channels, each producing a one-cycle clock-enable `tick` and a 50% square wave.
- Derives a CPU clock-enable with run/step/halt modes, so CPU logic stays on the single `clk` domain (no gated clocks).

Parameters:
- CNT_W, 32, width of free-running `clkdiv` counter
- N_CH, 4, number of divide channels (>=1)
- DIV_W, 24, width of per-channel divide value
- DEF_DIV, 24'd262143, reset divide value loaded into every channel
- STEP_W, 16, width of CPU enable-pulse counter

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- clkdiv  out  CNT_W  free-running cycle counter
- cfg_valid  in  1  divide-value write request
- cfg_ch  in  max(1,$clog2(N_CH))  target channel
- cfg_div  in  DIV_W  new divide value
- cfg_ready  out  1  write can be accepted this cycle
- ch_en  in  N_CH  per-channel run enable
- tick  out  N_CH  one-cycle pulse per channel period
- sq  out  N_CH  per-channel square wave
- cpu_mode  in  2  00 run, 01 step, 10/11 halt
- step_req  in  1  step request level, synchronous to clk
- cpu_ce  out  1  CPU clock-enable pulse
- step_cnt  out  STEP_W  count of cpu_ce pulses issued

Behaviour:
- Reset values (async, immediate):
  - clkdiv=0; every channel counter=0; div_reg=DEF_DIV; pending=0.
  - tick=0, sq=0, cpu_ce=0, step_cnt=0, step edge register=0.
- `clkdiv` increments by 1 every clk and wraps from all-ones to 0.
- Channel period:
  - Period is div_reg+1 cycles. The counter counts 0..div_reg.
  - When counter==div_reg, the counter returns to 0 and the registered `tick` is high the following cycle (1-cycle latency from compare).
  - div_reg=0 gives tick high every cycle while enabled.
  - `sq` toggles in the same cycle `tick` is asserted. sq period = 2*(div_reg+1).
- Channel disable:
  - ch_en[i]=0 holds counter at 0, tick[i]=0, and sq[i] at its current value.
  - Re-enable starts counting from 0; the first tick comes div_reg+1 cycles later.
- Config handshake:
  - A write is accepted when cfg_valid && cfg_ready at a clk edge.
  - Accepted value goes to pend_div[cfg_ch] and sets pending[cfg_ch].
  - cfg_ready = !pending[cfg_ch] (combinational on cfg_ch).
  - cfg_ch >= N_CH: cfg_ready=1 and the write is discarded.
- Glitch-free update:
  - A pending value is copied into div_reg only at that channel's wrap cycle (counter==div_reg), or on the next cycle if ch_en[i]=0. pending then clears.
  - The period in progress always completes with the old value.
  - A write in the same cycle as that channel's wrap is held pending until the next wrap (no same-cycle bypass).
- CPU enable:
  - run: cpu_ce = tick[0].
  - step: cpu_ce is high for exactly one cycle, one cycle after a 0->1 transition of step_req (registered edge detect). Holding step_req high gives a single pulse.
  - halt: cpu_ce=0.
  - Mode changes take effect on the next cycle. A tick[0] that arrives in the cycle cpu_mode leaves run is dropped.
  - A step_req edge seen while not in step mode is discarded; the edge register still tracks step_req.
- step_cnt increments on each cpu_ce pulse and wraps.
- Reset mid-period aborts the period and discards pending writes.

Decomposition:
- Shared package (clk_pkg): CPU mode encodings (CPU_RUN=2'b00, CPU_STEP=2'b01, CPU_HALT=2'b10) and the default DIV_W/DEF_DIV constants.
- One natural sub-module, clk_div_ch: a single channel holding counter, div_reg, pend_div, pending, tick and sq. Instantiate it N_CH times with a generate loop.
- The top level holds clkdiv, config decode and the CPU enable logic.

Test Plan:
- Reset then default ch_en=all 1 -> tick[0] first high at cycle 262144 after reset release, sq[0] toggles at same cycle; clkdiv==cycle count.
- Write ch1 div=3, ch_en[1]=1 -> tick[1] every 4 cycles, sq[1] period 8; div=0 -> tick[1] high every cycle.
- Ch2 running div=9, write div=1 mid-period -> cfg_ready(ch2)=0 until wrap, current 10-cycle period completes, then period 2; a second write while pending is not accepted.
- ch_en[3] toggled 1->0->1 mid-count -> tick[3]=0 and sq[3] frozen while disabled; first tick 6 cycles after re-enable with div=5; write during disable applies next cycle.
- cpu_mode=step, step_req held high 20 cycles then low, then pulsed 3 times -> exactly 4 cpu_ce pulses, step_cnt=4; halt -> no cpu_ce; run with div0=1 -> cpu_ce every 2 cycles.
- Assert rst asynchronously mid-period with a write pending -> all outputs 0 immediately, div_reg=DEF_DIV, pending cleared, cfg_ready=1.

Source files
------------

// File: rtl/clk_pkg.sv
`default_nettype none
// clk_pkg: CPU-mode encodings and default channel divide constants.
// Revision 1.0
package clk_pkg;

  localparam logic [1:0] CPU_RUN  = 2'b00;
  localparam logic [1:0] CPU_STEP = 2'b01;
  localparam logic [1:0] CPU_HALT = 2'b10;

  localparam int DEFAULT_DIV_W = 24;
  localparam logic [DEFAULT_DIV_W-1:0] DEFAULT_DEF_DIV = 24'd262143;

endpackage
`default_nettype wire

// File: rtl/clk_en_gen_if.sv
`default_nettype none
// clk_en_gen_if: config handshake, channel controls/outputs and CPU enable bundle.
// Revision 1.0
interface clk_en_gen_if import clk_pkg::*; #(
  parameter int CNT_W  = 32,
  parameter int N_CH   = 4,
  parameter int DIV_W  = DEFAULT_DIV_W,
  parameter int STEP_W = 16,
  parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
);

  logic [CNT_W-1:0]  clkdiv;
  logic              cfg_valid;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic              cfg_ready;
  logic [N_CH-1:0]   ch_en;
  logic [N_CH-1:0]   tick;
  logic [N_CH-1:0]   sq;
  logic [1:0]        cpu_mode;
  logic              step_req;
  logic              cpu_ce;
  logic [STEP_W-1:0] step_cnt;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, ch_en, cpu_mode, step_req,
    input  clkdiv, cfg_ready, tick, sq, cpu_ce, step_cnt
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, ch_en, cpu_mode, step_req,
    output clkdiv, cfg_ready, tick, sq, cpu_ce, step_cnt
  );

endinterface
`default_nettype wire

// File: rtl/clk_div_ch.sv
`default_nettype none
// clk_div_ch: one programmable divide channel with tick, square wave and wrap-aligned reload.
// Revision 1.0
module clk_div_ch import clk_pkg::*; #(
  parameter int               DIV_W   = DEFAULT_DIV_W,
  parameter logic [DIV_W-1:0] DEF_DIV = DEFAULT_DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             pending,
  output logic             tick,
  output logic             sq
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_pend_div;
  logic             w_wrap;

  assign w_wrap = en && (r_cnt == r_div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_div      <= DEF_DIV;
      r_pend_div <= '0;
      pending    <= 1'b0;
      tick       <= 1'b0;
      sq         <= 1'b0;
    end else begin
      if (!en || w_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
      tick <= w_wrap;
      if (w_wrap) begin
        sq <= ~sq;
      end
      // Reload only at a period boundary (or while idle) so no period is ever truncated.
      if (pending && (w_wrap || !en)) begin
        r_div   <= r_pend_div;
        pending <= 1'b0;
      end else if (wr && !pending) begin
        r_pend_div <= wr_div;
        pending    <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_en_gen.sv
`default_nettype none
// clk_en_gen: free-running clkdiv, N_CH divide channels and a run/step/halt CPU clock-enable.
// Revision 1.0
module clk_en_gen import clk_pkg::*; #(
  parameter int               CNT_W   = 32,
  parameter int               N_CH    = 4,
  parameter int               DIV_W   = DEFAULT_DIV_W,
  parameter logic [DIV_W-1:0] DEF_DIV = DEFAULT_DEF_DIV,
  parameter int               STEP_W  = 16
) (
  input  logic       clk,
  input  logic       rst,
  clk_en_gen_if.slave bus
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [CNT_W-1:0]  r_clkdiv;
  logic [N_CH-1:0]   w_pending;
  logic [N_CH-1:0]   w_wr;
  logic [N_CH-1:0]   w_tick;
  logic [N_CH-1:0]   w_sq;
  logic              w_cfg_ready;
  logic              w_ce_nxt;
  logic              r_step_q;
  logic              r_cpu_ce;
  logic [STEP_W-1:0] r_step_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clkdiv <= '0;
    end else begin
      r_clkdiv <= r_clkdiv + CNT_W'(1);
    end
  end

  // Out-of-range channel numbers match nothing: ready stays high and no write strobe fires.
  always_comb begin
    w_cfg_ready = 1'b1;
    w_wr        = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.cfg_ch == CH_W'(i)) begin
        w_cfg_ready = ~w_pending[i];
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      w_wr[i] = bus.cfg_valid && w_cfg_ready && (bus.cfg_ch == CH_W'(i));
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clk_div_ch #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.ch_en[i]),
      .wr      (w_wr[i]),
      .wr_div  (bus.cfg_div),
      .pending (w_pending[i]),
      .tick    (w_tick[i]),
      .sq      (w_sq[i])
    );
  end

  always_comb begin
    w_ce_nxt = 1'b0;
    case (bus.cpu_mode)
      CPU_RUN:  w_ce_nxt = w_tick[0];
      CPU_STEP: w_ce_nxt = bus.step_req && !r_step_q;
      CPU_HALT: w_ce_nxt = 1'b0;
      default:  w_ce_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step_q   <= 1'b0;
      r_cpu_ce   <= 1'b0;
      r_step_cnt <= '0;
    end else begin
      r_step_q <= bus.step_req;
      r_cpu_ce <= w_ce_nxt;
      if (w_ce_nxt) begin
        r_step_cnt <= r_step_cnt + STEP_W'(1);
      end
    end
  end

  assign bus.clkdiv    = r_clkdiv;
  assign bus.cfg_ready = w_cfg_ready;
  assign bus.tick      = w_tick;
  assign bus.sq        = w_sq;
  assign bus.cpu_ce    = r_cpu_ce;
  assign bus.step_cnt  = r_step_cnt;

endmodule
`default_nettype wire

// File: tb/tb_clk_en_gen.sv
`default_nettype none
// tb_clk_en_gen: queued-expectation scoreboard against a timestamp-based model of the channels and CPU enable.
// Revision 1.0
module tb_clk_en_gen;
  import clk_pkg::*;

  localparam int               N_CH       = 4;
  localparam logic [23:0]      TB_DEF_DIV = 24'd1023;

  typedef struct {
    int unsigned cyc;
    logic [31:0] clkdiv;
    logic [3:0]  tick;
    logic [3:0]  sq;
    logic [3:0]  pend;
    logic        ce;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  clk_en_gen_if #(.CNT_W(32), .N_CH(N_CH), .DIV_W(24), .STEP_W(16)) bus ();

  clk_en_gen #(
    .CNT_W   (32),
    .N_CH    (N_CH),
    .DIV_W   (24),
    .DEF_DIV (TB_DEF_DIV),
    .STEP_W  (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: each channel remembers the edge index at which its count last restarted.
  int unsigned n;
  int unsigned s[N_CH];
  logic [23:0] m_div[N_CH];
  logic [23:0] m_pdiv[N_CH];
  logic [3:0]  m_pend, m_tick, m_sq;
  logic        m_ce, m_step_q;
  logic [15:0] m_cnt;
  int          first_tick[N_CH];
  bit          rnd = 0;
  exp_t        q[$];
  exp_t        mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < N_CH; i++) begin
      s[i] = 0;
      m_div[i] = TB_DEF_DIV;
      m_pdiv[i] = '0;
      first_tick[i] = -1;
    end
    m_pend = '0; m_tick = '0; m_sq = '0;
    m_ce = 1'b0; m_step_q = 1'b0; m_cnt = '0;
    q.delete();
  endtask

  task automatic model_edge();
    logic [3:0] tk_prev;
    bit         wrap;
    tk_prev = m_tick;
    n++;
    for (int i = 0; i < N_CH; i++) begin
      wrap = bus.ch_en[i] && ((n - 1 - s[i]) == 32'(m_div[i]));
      if (!bus.ch_en[i] || wrap) s[i] = n;
      if (m_pend[i] && (wrap || !bus.ch_en[i])) begin
        m_div[i] = m_pdiv[i];
        m_pend[i] = 1'b0;
      end else if (bus.cfg_valid && int'(bus.cfg_ch) == i && !m_pend[i]) begin
        m_pdiv[i] = bus.cfg_div;
        m_pend[i] = 1'b1;
      end
      m_tick[i] = wrap;
      if (wrap) m_sq[i] = ~m_sq[i];
    end
    if (bus.cpu_mode == CPU_RUN)       m_ce = tk_prev[0];
    else if (bus.cpu_mode == CPU_STEP) m_ce = bus.step_req && !m_step_q;
    else                               m_ce = 1'b0;
    m_step_q = bus.step_req;
    if (m_ce) m_cnt = m_cnt + 16'd1;
  endtask

  task automatic rand_inputs();
    bus.cfg_valid = ($urandom % 4) == 0;
    bus.cfg_ch    = 2'($urandom_range(0, 3));
    bus.cfg_div   = 24'($urandom_range(0, 7));
    if (($urandom % 16) == 0) bus.ch_en[$urandom_range(0, 3)] ^= 1'b1;
    if (($urandom % 32) == 0) bus.cpu_mode = 2'($urandom_range(0, 3));
    bus.step_req  = ($urandom % 3) == 0;
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      model_edge();
      if (rnd) rand_inputs();
      q.push_back('{cyc: n, clkdiv: n, tick: m_tick, sq: m_sq, pend: m_pend, ce: m_ce, cnt: m_cnt});
    end
  endtask

  task automatic cfg_write(input int ch, input logic [23:0] div);
    bus.cfg_valid = 1'b1;
    bus.cfg_ch    = 2'(ch);
    bus.cfg_div   = div;
    run(1);
    bus.cfg_valid = 1'b0;
  endtask

  // Disabled channel takes a write on the following edge, so reprogramming is immediate.
  task automatic set_div_quick(input int ch, input logic [23:0] div);
    bus.ch_en[ch] = 1'b0;
    cfg_write(ch, div);
    run(2);
    bus.ch_en[ch] = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_clkdiv"},   64'(bus.clkdiv), 64'd0);
    check({tag, "_tick"},     64'(bus.tick), 64'd0);
    check({tag, "_sq"},       64'(bus.sq), 64'd0);
    check({tag, "_cpu_ce"},   64'(bus.cpu_ce), 64'd0);
    check({tag, "_step_cnt"}, 64'(bus.step_cnt), 64'd0);
    check({tag, "_cfg_ready"}, 64'(bus.cfg_ready), 64'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && q.size() > 0) begin
      mon_e = q.pop_front();
      check($sformatf("clkdiv@%0d", mon_e.cyc), 64'(bus.clkdiv), 64'(mon_e.clkdiv));
      check($sformatf("tick@%0d", mon_e.cyc), 64'(bus.tick), 64'(mon_e.tick));
      check($sformatf("sq@%0d", mon_e.cyc), 64'(bus.sq), 64'(mon_e.sq));
      check($sformatf("cpu_ce@%0d", mon_e.cyc), 64'(bus.cpu_ce), 64'(mon_e.ce));
      check($sformatf("step_cnt@%0d", mon_e.cyc), 64'(bus.step_cnt), 64'(mon_e.cnt));
      check($sformatf("cfg_ready@%0d", mon_e.cyc), 64'(bus.cfg_ready),
            64'(!mon_e.pend[bus.cfg_ch]));
      for (int i = 0; i < N_CH; i++)
        if (bus.tick[i] && first_tick[i] < 0) first_tick[i] = int'(mon_e.cyc);
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] base;
    bus.cfg_valid = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_div   = '0;
    bus.ch_en     = '1;
    bus.cpu_mode  = CPU_RUN;
    bus.step_req  = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Default divide on every channel: first tick one full period after reset.
    run(32'(TB_DEF_DIV) + 8);
    check("first_tick0", 64'(first_tick[0]), 64'(TB_DEF_DIV) + 64'd1);

    set_div_quick(1, 24'd3);
    run(40);
    cfg_write(1, 24'd0);
    run(20);

    // Mid-period write stays pending; a second write while pending is refused.
    set_div_quick(2, 24'd9);
    run(14);
    cfg_write(2, 24'd1);
    cfg_write(2, 24'd7);
    run(30);

    set_div_quick(3, 24'd5);
    run(9);
    bus.ch_en[3] = 1'b0;
    run(8);
    bus.ch_en[3] = 1'b1;
    run(20);
    bus.ch_en[3] = 1'b0;
    run(3);
    cfg_write(3, 24'd2);
    run(3);
    bus.ch_en[3] = 1'b1;
    run(20);

    bus.cpu_mode = CPU_STEP;
    bus.step_req = 1'b1;
    base = bus.step_cnt;
    run(20);
    bus.step_req = 1'b0;
    run(3);
    for (int k = 0; k < 3; k++) begin
      bus.step_req = 1'b1;
      run(1);
      bus.step_req = 1'b0;
      run(2);
    end
    check("step_pulses", 64'(16'(bus.step_cnt - base)), 64'd4);

    bus.cpu_mode = CPU_HALT;
    base = bus.step_cnt;
    run(30);
    check("halt_pulses", 64'(16'(bus.step_cnt - base)), 64'd0);

    set_div_quick(0, 24'd1);
    bus.cpu_mode = CPU_RUN;
    run(6);
    base = bus.step_cnt;
    run(20);
    check("run_div1_pulses", 64'(16'(bus.step_cnt - base)), 64'd10);

    rnd = 1;
    run(1500);
    rnd = 0;

    // Abort a period with a write pending on channel 2.
    bus.cfg_valid = 1'b0;
    bus.ch_en     = '1;
    bus.cpu_mode  = CPU_RUN;
    bus.step_req  = 1'b0;
    set_div_quick(2, 24'd50);
    run(5);
    cfg_write(2, 24'd3);
    run(2);
    check("pending_before_rst", 64'(bus.cfg_ready), 64'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(32'(TB_DEF_DIV) + 8);
    check("first_tick2_after_rst", 64'(first_tick[2]), 64'(TB_DEF_DIV) + 64'd1);
    @(negedge clk);
    #1;
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
